// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready producers.
// Define FIFO_ARB_BURST_EN to compile in the burst-lock FSM (up to BURST_LEN beats per grant).
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            full,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            burst_active
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be in 2..16");
    end
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("fifo_wr_arbiter: BURST_LEN must be >= 1");
    end

    // Modulo-NUM_REQ increment; keeps the pointer below NUM_REQ for any NUM_REQ.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : PTR_W'(32'(p) + 1);
    endfunction

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_win;
    logic [PTR_W-1:0] cand;
    logic             rr_found;
    logic [PTR_W-1:0] sel;
    logic             sel_vld;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] beat_cnt;

    always_comb begin
        sel     = rr_win;
        sel_vld = rr_found;
        if (state == BURST) begin
            sel     = owner;
            sel_vld = 1'b1;
        end
    end

    // Burst lock: the owner keeps the port until BURST_LEN beats or it drops valid.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else if (!full) begin
            case (state)
                IDLE: begin
                    if (w_en) begin
                        if (BURST_LEN > 1) begin
                            state    <= BURST;
                            owner    <= sel;
                            beat_cnt <= CNT_W'(1);
                        end else begin
                            rr_ptr <= ptr_inc(sel);
                        end
                    end
                end
                BURST: begin
                    if (!req_valid[owner] || (32'(beat_cnt) + 1 >= BURST_LEN)) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        rr_ptr   <= ptr_inc(owner);
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign burst_active = wrst_n && (state == BURST);
`else
    assign sel     = rr_win;
    assign sel_vld = rr_found;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rr_ptr <= '0;
        end else if (w_en) begin
            rr_ptr <= ptr_inc(sel);
        end
    end

    assign burst_active = 1'b0;
`endif

    // Reset gates the port so an in-flight beat is abandoned without a write.
    logic sel_live;
    assign sel_live  = sel_vld && wrst_n;
    assign grant     = sel_live ? (NUM_REQ'(1) << sel) : '0;
    assign req_ready = grant & {NUM_REQ{~full}};
    assign w_en      = |(req_valid & req_ready);
    assign data_in   = sel_live ? req_data[32'(sel) * DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Expectations follow the FIFO_ARB_BURST_EN setting of the build.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;

    logic                wclk;
    logic                wrst_n;
    logic [NR-1:0]       req_valid;
    logic [NR*DW-1:0]    req_data;
    logic [NR-1:0]       req_ready;
    logic                full;
    logic                w_en;
    logic [DW-1:0]       data_in;
    logic [NR-1:0]       grant;
    logic                burst_active;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .full         (full),
        .w_en         (w_en),
        .data_in      (data_in),
        .grant        (grant),
        .burst_active (burst_active)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        rst;
        logic [3:0]  grant;
        logic [3:0]  ready;
        logic        wen;
        logic [7:0]  din;
        logic        bact;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] D0 = 32'h4433_2211;
    localparam logic [31:0] DA = 32'h44A5_2211;

    function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic f,
                                input logic r, input logic [3:0] g, input logic [3:0] rd,
                                input logic we, input logic [7:0] di, input logic ba);
        vec_t t;
        t.valid = v; t.data = d; t.full = f; t.rst = r;
        t.grant = g; t.ready = rd; t.wen = we; t.din = di; t.bact = ba;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int  writes;
    logic hs;

    initial begin
        wrst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;

`ifndef FIFO_ARB_BURST_EN
        add(4'b0000, D0, 0, 1, 4'h0, 4'h0, 0, 8'h00, 0);
        add(4'b1111, D0, 0, 1, 4'h0, 4'h0, 0, 8'h00, 0);
        for (int k = 0; k < 2; k++) begin
            add(4'b1111, D0, 0, 0, 4'h1, 4'h1, 1, 8'h11, 0);
            add(4'b1111, D0, 0, 0, 4'h2, 4'h2, 1, 8'h22, 0);
            add(4'b1111, D0, 0, 0, 4'h4, 4'h4, 1, 8'h33, 0);
            add(4'b1111, D0, 0, 0, 4'h8, 4'h8, 1, 8'h44, 0);
        end
        for (int k = 0; k < 3; k++) add(4'b0100, DA, 1, 0, 4'h4, 4'h0, 0, 8'hA5, 0);
        add(4'b0100, DA, 0, 0, 4'h4, 4'h4, 1, 8'hA5, 0);
        add(4'b1010, DA, 0, 0, 4'h8, 4'h8, 1, 8'h44, 0);
        add(4'b1010, DA, 0, 0, 4'h2, 4'h2, 1, 8'h22, 0);
        add(4'b0000, DA, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
        add(4'b0000, DA, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0);
        add(4'b0011, DA, 0, 0, 4'h1, 4'h1, 1, 8'h11, 0);
        add(4'b0011, DA, 1, 0, 4'h2, 4'h0, 0, 8'h22, 0);
        add(4'b0011, DA, 0, 0, 4'h2, 4'h2, 1, 8'h22, 0);
        add(4'b1111, DA, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0);
        add(4'b1111, DA, 0, 0, 4'h1, 4'h1, 1, 8'h11, 0);
`else
        add(4'b0000, D0, 0, 1, 4'h0, 4'h0, 0, 8'h00, 0);
        for (int k = 0; k < 4; k++) add(4'b1111, D0, 0, 0, 4'h1, 4'h1, 1, 8'h11, k != 0);
        for (int k = 0; k < 4; k++) add(4'b1111, D0, 0, 0, 4'h2, 4'h2, 1, 8'h22, k != 0);
        add(4'b1111, D0, 0, 0, 4'h4, 4'h4, 1, 8'h33, 0);
        add(4'b1111, D0, 0, 0, 4'h4, 4'h4, 1, 8'h33, 1);
        add(4'b1011, D0, 0, 0, 4'h4, 4'h4, 0, 8'h33, 1);
        add(4'b1011, D0, 0, 0, 4'h8, 4'h8, 1, 8'h44, 0);
        add(4'b1011, D0, 1, 0, 4'h8, 4'h0, 0, 8'h44, 1);
        add(4'b1011, D0, 0, 0, 4'h8, 4'h8, 1, 8'h44, 1);
        add(4'b1011, D0, 0, 1, 4'h0, 4'h0, 0, 8'h00, 0);
        add(4'b1111, D0, 0, 0, 4'h1, 4'h1, 1, 8'h11, 0);
`endif

        foreach (tbl[i]) begin
            @(negedge wclk);
            wrst_n    = ~tbl[i].rst;
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            full      = tbl[i].full;
            #1;
            check($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].grant));
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            check($sformatf("v%0d w_en", i), 32'(w_en), 32'(tbl[i].wen));
            check($sformatf("v%0d data_in", i), 32'(data_in), 32'(tbl[i].din));
            check($sformatf("v%0d burst_active", i), 32'(burst_active), 32'(tbl[i].bact));
        end

        // Producer on req 1 stalls behind full, then drops valid once it sees ready.
        @(negedge wclk);
        req_valid = '0;
        req_data  = D0;
        full      = 1'b0;
        hs        = 1'b0;
        writes    = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge wclk);
            full      = (c < 3);
            req_valid = hs ? 4'b0000 : 4'b0010;
            #1;
            if (full) check($sformatf("stall%0d w_en", c), 32'(w_en), 32'(0));
            if (w_en) begin
                writes++;
                check("single data_in", 32'(data_in), 32'h22);
            end
            if (req_valid[1] && req_ready[1]) hs = 1'b1;
        end
        check("single handshake", 32'(hs), 32'(1));
        check("single writes", 32'(writes), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the FIFO memory among `NUM_REQ` producers in the write clock domain. Each producer offers data with a valid/ready handshake; the arbiter picks one winner per cycle, drives `w_en`/`data_in` into the FIFO memory, and back-pressures all producers while `full` is high. The arbiter sits between the producer blocks and the FIFO's write side; it holds a registered fairness pointer and, optionally, a burst-lock FSM.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: data word width; matches the FIFO memory.
- `BURST_LEN`, default 4: maximum beats per grant when burst lock is compiled in; ≥1.

- `wclk` in 1: write-domain clock, rising edge.
- `wrst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester data-valid.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: one-hot or zero; beat i transfers when `req_valid[i] & req_ready[i]`.
- `full` in 1: FIFO full flag, write domain.
- `w_en` out 1: FIFO write enable.
- `data_in` out DATA_WIDTH: FIFO write data.
- `grant` out NUM_REQ: one-hot current winner, or zero; may be high while `full` stalls.
- `burst_active` out 1: high while the burst FSM is in BURST; constant 0 when the macro is absent.

## Operation
- State: `rr_ptr` (clog2(NUM_REQ) bits, highest-priority index), plus `owner`, `beat_cnt`, and FSM {IDLE, BURST} when burst lock is compiled in.
- Winner search: first i with `req_valid[i]=1`, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. No valid requester → `grant=0`.
- Outputs are combinational from state and inputs:
  - `grant` = one-hot winner.
  - `req_ready` = `grant & {NUM_REQ{~full}}`.
  - `w_en` = `|(req_valid & req_ready)`.
  - `data_in` = winner's slice; 0 when `grant=0`.
- Transfer in a cycle (w_en=1): `rr_ptr <= winner+1` modulo NUM_REQ. Wrap: NUM_REQ-1 → 0. For non-power-of-two NUM_REQ, rr_ptr never takes values ≥ NUM_REQ.
- `full=1`: no transfer; rr_ptr, owner, beat_cnt, and FSM state are unchanged. `grant` still reflects the winner.
- Requesters hold `req_valid` and `req_data` stable until they see ready. The arbiter never drops or duplicates a beat, and never asserts `w_en` with `full=1`.
- Reset (`wrst_n=0`, any time, including mid-burst): rr_ptr=0, FSM=IDLE, owner=0, beat_cnt=0. Outputs follow combinationally: with all `req_valid=0`, then `grant`, `req_ready`, `w_en`, `data_in`, and `burst_active` are all 0. A beat in flight is abandoned with no write.

## Timing
- Zero-cycle latency: a beat accepted in cycle t is written by the FIFO memory at the same `wclk` edge that ends cycle t.
- Throughput: 1 beat/cycle while `full=0` and any requester is valid.
- Fairness: with all requesters continuously valid, each requester wins once per NUM_REQ beats (no burst), or once per NUM_REQ*BURST_LEN beats (burst).
- `full` is sampled in the same cycle it gates; the FIFO's registered full guarantees no overflow.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- Defined: burst FSM is present.
  - IDLE: a transfer from winner k with BURST_LEN>1 → BURST, owner=k, beat_cnt=1, rr_ptr unchanged.
  - BURST: `grant` is forced to owner. Each transfer increments beat_cnt.
  - BURST → IDLE when a transfer brings beat_cnt to BURST_LEN, with rr_ptr<=owner+1.
  - BURST → IDLE when `req_valid[owner]=0`: no transfer that cycle, rr_ptr<=owner+1.
  - `full` in BURST: FSM holds.
- Absent: pure per-beat round robin; no FSM or counter logic; `burst_active` tied to 0.

## Test plan
- Reset, then all valid, full=0, no macro: 8 cycles → grants 0,1,2,3,0,1,2,3; `data_in` equals the respective slice every cycle.
- Only req 2 valid with data 0xA5, then full=1 for 3 cycles → `w_en=0` and `req_ready=0` for 3 cycles, `grant=4'b0100` held; on full=0, one write of 0xA5 and rr_ptr becomes 3.
- rr_ptr=3, reqs 1 and 3 valid → req 3 wins, rr_ptr wraps to 0, then req 1 wins.
- Macro on, BURST_LEN=4, all valid → 4 consecutive beats from req 0 with `burst_active` high for beats 2–4, then 4 beats from req 1.
- Macro on, owner 2 drops valid after 2 beats → FSM returns to IDLE, no write that cycle, next grant goes to req 3.
- Assert `wrst_n=0` mid-burst on beat 3 → `burst_active=0` and `w_en=0` immediately; after release, arbitration restarts from req 0.
